// File: rtl/reg_file_multiport.sv
// reg_file_multiport
//   Register file of 2**ADDR_W entries of DATA_W bits with NUM_RD registered
//   read ports and one write port. After reset, an initialiser writes each
//   entry with its own index, one entry per cycle. Port writes are ignored
//   during that time. Reads see a same-cycle write first (bypass). An optional
//   hardwired zero register is available. Read data is captured into output
//   registers under ld and cleared under clr.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-low
//   wr       in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read addresses, port k at [k*ADDR_W +: ADDR_W]
//   ld       in   capture read values into all output registers
//   clr      in   synchronous clear of all output registers (wins over ld)
//   rd_data  out  registered read data, port k at [k*DATA_W +: DATA_W]
//   busy     out  high while the initialiser runs
module reg_file_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     ld,
    input  logic                     clr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W:0]            init_cnt_q, init_cnt_d;
    logic                       busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]          mem_q [DEPTH];
    logic                       init_we;
    logic                       init_last;
    logic                       port_we;

    assign init_last = (init_cnt_q == {1'b0, {ADDR_W{1'b1}}});

    // State register and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            busy_q     <= 1'b1;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // FSM outputs: initialiser write strobe, counter advance, registered busy
    always_comb begin
        init_we    = 1'b0;
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            init_we    = 1'b1;
            init_cnt_d = init_cnt_q + (ADDR_W + 1)'(1);
        end
        busy_d = (state_d == INIT);
    end

    // A port write takes effect only in RUN and never targets a hardwired zero entry
    assign port_we = (state_q == RUN) && wr && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_cnt_q[ADDR_W-1:0]] <= DATA_W'(init_cnt_q);
        end else if (port_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read values: zero register overrides bypass, bypass overrides the array
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] v;
        ra        = '0;
        v         = '0;
        rd_data_d = rd_data_q;
        if (clr) begin
            rd_data_d = '0;
        end else if (ld) begin
            for (int unsigned k = 0; k < NUM_RD; k++) begin
                ra = rd_addr[k*ADDR_W +: ADDR_W];
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    v = '0;
                end else if (port_we && (wr_addr == ra)) begin
                    v = wr_data;
                end else begin
                    v = mem_q[ra];
                end
                rd_data_d[k*DATA_W +: DATA_W] = v;
            end
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_reg_file_multiport.sv
// Testbench for reg_file_multiport: two instances (ZERO_REG=0 and ZERO_REG=1)
// share all inputs and are compared against a behavioural model.
module tb_reg_file_multiport;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr;
    logic        ld;
    logic        clr;
    logic [63:0] rd_data0, rd_data1;
    logic        busy0, busy1;

    reg_file_multiport #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .ld(ld), .clr(clr), .rd_data(rd_data0), .busy(busy0)
    );

    reg_file_multiport #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .ld(ld), .clr(clr), .rd_data(rd_data1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, array contents and expected outputs.
    // cyc counts rising edges since the last reset release; the first 16
    // edges belong to the initialiser.
    logic [31:0] m [2][16];
    logic [63:0] exp_rd [2];
    int          cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr  = 1'b0;
        ld  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic check_all();
        logic exp_busy;
        exp_busy = (cyc < 16);
        check("busy_z0", {63'd0, busy0}, {63'd0, exp_busy});
        check("busy_z1", {63'd0, busy1}, {63'd0, exp_busy});
        check("rd_z0", rd_data0, exp_rd[0]);
        check("rd_z1", rd_data1, exp_rd[1]);
    endtask

    // Apply the current inputs for one rising edge, then compare.
    task automatic step();
        logic [31:0] v;
        logic [3:0]  a;
        bit          run;
        bit          drop;
        run = (cyc >= 16);
        for (int z = 0; z < 2; z++) begin
            drop = !run || !wr || (z == 1 && wr_addr == 4'd0);
            if (clr) begin
                exp_rd[z] = '0;
            end else if (ld) begin
                for (int k = 0; k < 2; k++) begin
                    a = rd_addr[k*4 +: 4];
                    if (z == 1 && a == 4'd0)          v = '0;
                    else if (!drop && wr_addr == a)  v = wr_data;
                    else                              v = m[z][a];
                    exp_rd[z][k*32 +: 32] = v;
                end
            end
            if (!run)       m[z][cyc] = 32'(cyc);
            else if (!drop) m[z][wr_addr] = wr_data;
        end
        cyc++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Short reset pulse placed between clock edges (caller is just after a posedge).
    task automatic do_reset();
        rst = 1'b0;
        #2;
        cyc       = 0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        check_all();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        wr      = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        ld      = 1'b0;
        clr     = 1'b0;
        cyc     = 0;
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 16; i++) m[z][i] = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Write during INIT (ignored), then reset restart at cycle 8 of INIT
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i == 3) begin
                wr      = 1'b1;
                wr_addr = 4'd12;
                wr_data = 32'hAAAA_5555;
            end
            step();
        end
        idle();
        do_reset();
        check("t6_rd_after_rst", rd_data0, 64'd0);

        // Initialiser runs 16 cycles with ld held low
        for (int i = 0; i < 16; i++) begin
            step();
            check("t1_busy", {63'd0, busy0}, (i < 15) ? 64'd1 : 64'd0);
        end

        rd_addr = {4'd9, 4'd5};
        ld      = 1'b1;
        step();
        check("t1_init_vals", rd_data0, {32'd9, 32'd5});

        rd_addr = {4'd12, 4'd12};
        step();
        check("t6_addr12", rd_data0, {32'd12, 32'd12});

        // Plain write, then read next cycle; neighbour entry unchanged
        idle();
        wr      = 1'b1;
        wr_addr = 4'd3;
        wr_data = 32'hDEAD_BEEF;
        step();
        idle();
        ld      = 1'b1;
        rd_addr = {4'd4, 4'd3};
        step();
        check("t2_write_read", rd_data0, {32'd4, 32'hDEAD_BEEF});

        // Write-first bypass on both ports, then re-read from the array
        wr      = 1'b1;
        wr_addr = 4'd7;
        wr_data = 32'h1234_5678;
        rd_addr = {4'd7, 4'd7};
        step();
        check("t3_bypass", rd_data0, {2{32'h1234_5678}});
        idle();
        step();
        ld = 1'b1;
        step();
        check("t3_reread", rd_data1, {2{32'h1234_5678}});

        // clr wins over ld; then hold
        clr = 1'b1;
        step();
        check("t4_clr", rd_data0, 64'd0);
        idle();
        step();
        check("t4_hold", rd_data0, 64'd0);

        // Zero register vs. ordinary entry 0
        wr      = 1'b1;
        wr_addr = 4'd0;
        wr_data = 32'hFFFF_FFFF;
        ld      = 1'b1;
        rd_addr = {4'd0, 4'd0};
        step();
        check("t5_z0_now", rd_data0, {2{32'hFFFF_FFFF}});
        check("t5_z1_now", rd_data1, 64'd0);
        wr = 1'b0;
        step();
        check("t5_z0_after", rd_data0, {2{32'hFFFF_FFFF}});
        check("t5_z1_after", rd_data1, 64'd0);

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 600; i++) begin
            wr      = ($urandom_range(0, 1) == 1);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_addr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rd_addr[7:4] = wr_addr;
            ld      = ($urandom_range(0, 9) < 6);
            clr     = ($urandom_range(0, 9) == 0);
            step();
            if ($urandom_range(0, 149) == 0) begin
                idle();
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
